idst7_mac_sched: RTL and testbench

IDST7_MAC_SCHED -- requirements
Module: idst7_mac_sched

---
 rtl/idst7_mac_sched.sv | 172 +++++++++++++++++
 tb/tb_idst7_mac_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idst7_mac_sched.sv
// idst7_mac_sched
// Four-point integer inverse DST-VII stage built around one shared external
// 8s x 32s multiplier. One four-sample vector is accepted at a time. Its 16
// products are issued one per cycle, and each product is accumulated into its
// output lane one cycle later. The rounded, arithmetically shifted results are
// then presented to downstream under a valid/ready handshake.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   in_valid/in_ready   input vector handshake (in_ready high only in IDLE)
//   in_data[127:0]      x[k] = in_data[32k+31:32k], signed
//   out_valid/out_ready result handshake; out_data held until accepted
//   out_data[127:0]     y[i] = out_data[32i+31:32i], signed
//   mul_ce              clock enable to the shared multiplier
//   mul_din0[7:0]       signed coefficient operand
//   mul_din1[31:0]      signed sample operand
//   mul_dout[31:0]      low 32 bits of the product, one ce-cycle after issue
module idst7_mac_sched #(
   parameter int SHIFT    = 7,
   parameter bit ROUND_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         mul_ce,
   output logic [7:0]   mul_din0,
   output logic [31:0]  mul_din1,
   input  logic [31:0]  mul_dout
);

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   localparam logic [31:0] RND = ROUND_EN ? (32'd1 << (SHIFT - 1)) : 32'd0;

   state_t        state;
   state_t        state_next;
   logic [3:0]    cnt;
   logic [3:0]    cnt_p1;
   logic [3:0]    cnt_m1;
   logic [127:0]  x_reg;
   logic [31:0]   acc [4];
   logic [127:0]  result_next;

   // Coefficient C[k][i]; product p uses k = p%4 and i = p/4.
   function automatic logic [7:0] coef(input logic [1:0] k, input logic [1:0] i);
      logic [7:0] c;
      case ({k, i})
         4'h0: c = 8'd29;
         4'h1: c = 8'd55;
         4'h2: c = 8'd74;
         4'h3: c = 8'd84;
         4'h4: c = 8'd74;
         4'h5: c = 8'd74;
         4'h6: c = 8'd0;
         4'h7: c = -8'sd74;
         4'h8: c = 8'd84;
         4'h9: c = -8'sd29;
         4'hA: c = -8'sd74;
         4'hB: c = 8'd55;
         4'hC: c = 8'd55;
         4'hD: c = -8'sd84;
         4'hE: c = 8'd74;
         default: c = -8'sd29;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] sel_word(input logic [127:0] v, input logic [1:0] k);
      logic [31:0] w;
      case (k)
         2'd0: w = v[31:0];
         2'd1: w = v[63:32];
         2'd2: w = v[95:64];
         default: w = v[127:96];
      endcase
      return w;
   endfunction

   assign in_ready = (state == IDLE);
   assign cnt_p1   = cnt + 4'd1;
   assign cnt_m1   = cnt - 4'd1;

   // Final results, used on the DRAIN edge. Lanes 0..2 are complete by then.
   // Lane 3 still needs the last product, which is sitting on mul_dout.
   always_comb begin
      result_next = '0;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] s;
         s = acc[i] + RND;
         if (i == 3) s = s + mul_dout;
         result_next[32*i +: 32] = $signed(s) >>> SHIFT;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic. MAC runs for cnt = 0..15, one product per cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid) state_next = MAC;
         MAC:     if (cnt == 4'd15) state_next = DRAIN;
         DRAIN:   state_next = OUT;
         OUT:     if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath. Multiplier operands are registered, so the operands for
   // product p are loaded on the edge before the cycle that issues it.
   // Product 0 is loaded on the acceptance edge straight from in_data. The
   // product issued while cnt = q is on mul_dout while cnt = q+1, so it is
   // accumulated into lane (q)/4 on that edge. Product 15 lands in DRAIN.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         x_reg     <= '0;
         for (int i = 0; i < 4; i++) acc[i] <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         mul_ce    <= 1'b0;
         mul_din0  <= '0;
         mul_din1  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= in_data;
                  for (int i = 0; i < 4; i++) acc[i] <= '0;
                  cnt      <= 4'd0;
                  mul_ce   <= 1'b1;
                  mul_din0 <= coef(2'd0, 2'd0);
                  mul_din1 <= in_data[31:0];
               end
            end
            MAC: begin
               if (cnt != 4'd0) acc[cnt_m1[3:2]] <= acc[cnt_m1[3:2]] + mul_dout;
               if (cnt == 4'd15) begin
                  mul_din0 <= '0;
                  mul_din1 <= '0;
               end else begin
                  mul_din0 <= coef(cnt_p1[1:0], cnt_p1[3:2]);
                  mul_din1 <= sel_word(x_reg, cnt_p1[1:0]);
               end
               cnt <= cnt_p1;
            end
            DRAIN: begin
               acc[3]    <= acc[3] + mul_dout;
               out_data  <= result_next;
               out_valid <= 1'b1;
               mul_ce    <= 1'b0;
               mul_din0  <= '0;
               mul_din1  <= '0;
            end
            OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_idst7_mac_sched.sv
// Testbench for idst7_mac_sched. Two instances run in lockstep on the same
// stimulus: one with rounding, one without. Each has its own model of the
// shared multiplier. Expected results are pushed into queues at acceptance.
// A negedge monitor pops them at each output handshake and also checks
// latency, hold behaviour, the issue sequence and the post-reset state.
module tb_idst7_mac_sched;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [127:0] in_data = '0;

   logic         in_ready_a, out_valid_a, mul_ce_a;
   logic [127:0] out_data_a;
   logic [7:0]   din0_a;
   logic [31:0]  din1_a;
   logic [31:0]  mul_dout_a = 32'hdead_beef;

   logic         in_ready_b, out_valid_b, mul_ce_b;
   logic [127:0] out_data_b;
   logic [7:0]   din0_b;
   logic [31:0]  din1_b;
   logic [31:0]  mul_dout_b = 32'h1234_5678;

   localparam int COEF [4][4] = '{'{29, 55, 74, 84}, '{74, 74, 0, -74},
                                  '{84, -29, -74, 55}, '{55, -84, 74, -29}};

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int accept_count = 0;
   bit stream_mode = 1'b0;

   logic [127:0] exp_a_q [$];
   logic [127:0] exp_b_q [$];
   int           lat_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   idst7_mac_sched dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .mul_ce(mul_ce_a), .mul_din0(din0_a),
      .mul_din1(din1_a), .mul_dout(mul_dout_a)
   );

   idst7_mac_sched #(.SHIFT(7), .ROUND_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .mul_ce(mul_ce_b), .mul_din0(din0_b),
      .mul_din1(din1_b), .mul_dout(mul_dout_b)
   );

   // Shared multiplier models: low 32 bits of the signed product, one ce-cycle late.
   always @(posedge clk) if (mul_ce_a) mul_dout_a <= 32'($signed(din0_a) * $signed(din1_a));
   always @(posedge clk) if (mul_ce_b) mul_dout_b <= 32'($signed(din0_b) * $signed(din1_b));

   // Reference transform: plain 32-bit wrapping integer arithmetic.
   function automatic logic [127:0] ref_model(input logic [127:0] x, input bit rnd_en);
      logic [127:0] y = '0;
      for (int i = 0; i < 4; i++) begin
         int s = 0;
         for (int k = 0; k < 4; k++) s += COEF[k][i] * int'($signed(x[32*k +: 32]));
         if (rnd_en) s += 64;
         y[32*i +: 32] = s >>> 7;
      end
      return y;
   endfunction

   function automatic logic [127:0] rand_vec();
      logic [127:0] v;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 1) == 1) v[32*k +: 32] = $urandom;
         else v[32*k +: 32] = 32'($urandom_range(0, 1023)) - 32'd512;
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Monitor / scoreboard.
   bit           active = 1'b0;
   int           t_acc = 0;
   logic [127:0] x_acc = '0;
   int           last_accept = -1;
   int           expect_accept = -1;
   bit           prev_reset = 1'b0;
   bit           prev_valid = 1'b0;
   bit           prev_ready = 1'b0;
   logic [127:0] prev_data = '0;

   always @(negedge clk) begin
      int d;
      int p;
      logic [40:0] mexp;

      if (prev_reset)
         checkOutput("post_reset",
                     {out_valid_a, out_data_a, mul_ce_a, din0_a, din1_a, in_ready_a, out_valid_b, out_data_b},
                     {1'b0, 128'd0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 128'd0});

      mexp = '0;
      if (active) begin
         d = cyc - t_acc;
         if (d >= 1 && d <= 16) begin
            p = d - 1;
            mexp = {1'b1, 8'(COEF[p % 4][p / 4]), x_acc[32*(p % 4) +: 32]};
         end else if (d == 17) begin
            mexp = {1'b1, 40'd0};
         end else begin
            active = 1'b0;
         end
      end
      checkOutput("mul_issue", {mul_ce_a, din0_a, din1_a}, mexp);

      checkOutput("lockstep_b", {out_valid_b, in_ready_b}, {out_valid_a, in_ready_a});

      if (out_valid_a && !prev_valid) begin
         if (lat_q.size() == 0) checkOutput("unexpected_out_valid", out_valid_a, 1'b0);
         else checkOutput("latency", cyc, lat_q.pop_front() + 18);
      end
      if (prev_valid && !prev_ready)
         checkOutput("out_hold", {out_valid_a, out_data_a}, {1'b1, prev_data});
      if (out_valid_a) checkOutput("in_ready_in_out", in_ready_a, 1'b0);
      if (expect_accept == cyc) begin
         checkOutput("accept_after_handshake", in_ready_a, 1'b1);
         expect_accept = -1;
      end

      if (reset) begin
         exp_a_q.delete();
         exp_b_q.delete();
         lat_q.delete();
         active = 1'b0;
         expect_accept = -1;
         prev_valid = 1'b0;
      end else begin
         if (out_valid_a && out_ready) begin
            if (exp_a_q.size() == 0) begin
               checkOutput("unexpected_handshake", out_valid_a, 1'b0);
            end else begin
               checkOutput("y_round", out_data_a, exp_a_q.pop_front());
               checkOutput("y_noround", out_data_b, exp_b_q.pop_front());
            end
            if (in_valid) expect_accept = cyc + 1;
         end
         if (in_valid && in_ready_a) begin
            exp_a_q.push_back(ref_model(in_data, 1'b1));
            exp_b_q.push_back(ref_model(in_data, 1'b0));
            lat_q.push_back(cyc);
            if (stream_mode && last_accept >= 0)
               checkOutput("accept_spacing", cyc - last_accept, 19);
            last_accept = stream_mode ? cyc : -1;
            active = 1'b1;
            t_acc = cyc;
            x_acc = in_data;
            accept_count++;
         end
         prev_valid = out_valid_a;
      end
      prev_ready = out_ready;
      prev_data = out_data_a;
      prev_reset = reset;
   end

   // Present one vector and hold in_valid until it is accepted.
   task automatic applyStimulus(input logic [127:0] x);
      bit ok = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = x;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("accept_wait");
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data = rand_vec();
   endtask

   task automatic waitIdle();
      bit ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (exp_a_q.size() == 0 && !out_valid_a && in_ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("idle_wait");
   endtask

   initial begin
      bit ok;
      int target;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] directed vectors");
      applyStimulus({32'd0, 32'd0, 32'd0, 32'd64});
      waitIdle();
      applyStimulus({32'd0, 32'd0, 32'd128, 32'd0});
      waitIdle();

      $display("[TB] output backpressure");
      out_ready = 1'b0;
      applyStimulus(rand_vec());
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (out_valid_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("out_valid_wait");
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data = rand_vec();
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready_a) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("reaccept_wait");
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitIdle();

      $display("[TB] reset during MAC");
      applyStimulus(rand_vec());
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      applyStimulus({32'd0, 32'd0, 32'd0, 32'd64});
      waitIdle();

      $display("[TB] back-to-back stream");
      stream_mode = 1'b1;
      out_ready = 1'b1;
      target = accept_count + 5;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = rand_vec();
      for (int n = 0; n < 300 && accept_count < target; n++) begin
         @(negedge clk);
         if (in_ready_a) begin
            @(posedge clk); #1;
            in_data = rand_vec();
         end
      end
      if (accept_count < target) timeoutFail("stream_wait");
      in_valid = 1'b0;
      waitIdle();
      stream_mode = 1'b0;

      $display("[TB] random traffic");
      target = accept_count + 20;
      for (int n = 0; n < 4000 && accept_count < target; n++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = rand_vec();
         out_ready = ($urandom_range(0, 2) != 0);
      end
      if (accept_count < target) timeoutFail("random_wait");
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      waitIdle();

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
